tt_bin_clock_buttons: RTL and testbench
=======================================

Name: tt_bin_clock_buttons

Overview:
- Front-end conditioner for the binary clock's time-setting controls.
- Synchronises and debounces five raw switch/button inputs sampled at the 100 Hz system clock.
- Produces clean levels for the time-set and inc/dec switches.
- Produces single-cycle step pulses for the hour/minute/seconds buttons, with optional hold-to-auto-repeat.
- Outputs drive the time_set, id_switch, hour_id, minute_id and seconds_id inputs of the clock core directly downstream.

Parameters:
- DEBOUNCE_CYCLES, 3, consecutive stable cycles required before a debounced level changes (1..255).
- REPEAT_DELAY, 50, cycles a button is held after its first pulse before auto-repeat begins (2..255).
- REPEAT_PERIOD, 20, cycles between auto-repeat pulses (2..255).

Ports:
- clk_i  input  1  system clock, 100 Hz
- reset_i  input  1  reset, asynchronous, active-high
- time_set_raw  input  1  raw set-mode switch, asynchronous to clk_i
- id_switch_raw  input  1  raw increment(1)/decrement(0) switch
- hour_btn_raw  input  1  raw hour button, 1 = pressed
- minute_btn_raw  input  1  raw minute button, 1 = pressed
- seconds_btn_raw  input  1  raw seconds button, 1 = pressed
- time_set  output  1  debounced set-mode level
- id_switch  output  1  debounced inc/dec level
- hour_id  output  1  one-cycle hour step pulse
- minute_id  output  1  one-cycle minute step pulse
- seconds_id  output  1  one-cycle seconds step pulse

Behaviour:
- One clock (clk_i); reset_i is asynchronous, active-high.
- Reset clears all synchronisers, debounce counters, debounced levels, the FSM (to IDLE) and the repeat counter. All outputs read 0 during and after reset until inputs qualify.
- Synchronisation: each raw input passes through a 2-flop synchroniser.
- Debounce: a per-input 8-bit counter increments while the synchronised value differs from the current debounced level, and clears when they match. When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Glitches shorter than DEBOUNCE_CYCLES cycles never reach any output.
- time_set and id_switch are the registered debounced levels.
- Latency: a clean raw transition appears on a debounced level exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples it.
- Step FSM states: IDLE, DELAY, REPEAT, HOLD. A 2-bit lock register selects the tracked button. An 8-bit repeat counter is used in DELAY and REPEAT.
- IDLE:
  - Acts on a debounced rising edge of any button while debounced time_set = 1.
  - Locks the highest-priority rising button (seconds > minute > hour).
  - Asserts that button's pulse for exactly one cycle, on the cycle after the debounced rise.
  - Clears the counter and goes to DELAY (HOLD if auto-repeat is compiled out).
- DELAY:
  - Locked button released → IDLE, no pulse.
  - Counter reaches REPEAT_DELAY-1 → one pulse, counter cleared, go to REPEAT.
- REPEAT:
  - Locked button released → IDLE.
  - Counter reaches REPEAT_PERIOD-1 → one pulse, counter cleared, remain in REPEAT.
- HOLD: locked button released → IDLE; no pulses.
- Non-locked buttons are ignored while locked. A button still held when the lock releases does not pulse until it is released and pressed again, because only rising edges are accepted.
- Debounced time_set = 0 in any state → IDLE next cycle, counter cleared, all pulses forced 0 that cycle.
- Simultaneous rising edges on several buttons: only the highest-priority button pulses. The others are treated as held.
- At most one of hour_id/minute_id/seconds_id is high in any cycle. No pulse is ever longer than 1 cycle.
- id_switch changes during a hold take effect on the next pulse; the FSM is unaffected.
- reset_i asserted mid-hold: immediate return to IDLE, pulses 0. A button held through reset release does not pulse until it is re-pressed.

Optional Feature:
- Macro: TT_BIN_CLOCK_AUTO_REPEAT_EN.
- Defined: DELAY/REPEAT behaviour as above; the HOLD state is unused.
- Undefined: IDLE goes straight to HOLD; exactly one pulse per press regardless of hold length; REPEAT_DELAY and REPEAT_PERIOD are ignored, and the repeat counter and DELAY/REPEAT logic are not built.

Test Plan:
Defaults (3/50/20).
- Reset then idle inputs → all outputs 0; time_set_raw rises → time_set=1 exactly 5 edges later; a 2-cycle glitch on id_switch_raw → id_switch unchanged.
- time_set=1, seconds_btn_raw held 10 cycles → exactly one seconds_id pulse, 1 cycle wide, 6 edges after the raw rise; no further pulses.
- time_set=1, minute_btn_raw held 120 cycles with AUTO_REPEAT_EN → pulses at relative cycles 0, 50, 70, 90, 110 (5 total); without the macro → 1 pulse.
- hour and seconds raw rise in the same cycle and are held 30 cycles → only seconds_id pulses; after seconds is released with hour still held → no hour_id pulse until hour is re-pressed.
- Button held with time_set_raw dropped mid-REPEAT → pulses stop within 1 cycle of debounced time_set falling; time_set re-raised while still held → no pulse.
- reset_i pulsed asynchronously between clock edges during a DELAY hold → outputs 0 immediately; after release, button still held → no pulse; release and re-press → one pulse.

Source files
------------

// File: rtl/tt_bin_clock_buttons.sv
// ---------------------------------------------------------------------------
// tt_bin_clock_buttons
// Input conditioner for the binary clock's time-setting controls. Five raw
// switch/button inputs are synchronised and debounced. The two switches come
// out as clean levels. The three buttons come out as single-cycle step
// pulses, which are only produced while the debounced time_set level is high.
//
// Optional feature: define TT_BIN_CLOCK_AUTO_REPEAT_EN to build hold-to-
// auto-repeat (DELAY/REPEAT states plus repeat counter). Without it every
// press yields exactly one pulse (HOLD state).
//
// Ports:
//   clk_i            system clock (100 Hz)
//   reset_i          asynchronous, active-high reset
//   time_set_raw     raw set-mode switch
//   id_switch_raw    raw increment(1)/decrement(0) switch
//   hour_btn_raw     raw hour button, 1 = pressed
//   minute_btn_raw   raw minute button, 1 = pressed
//   seconds_btn_raw  raw seconds button, 1 = pressed
//   time_set         debounced set-mode level
//   id_switch        debounced inc/dec level
//   hour_id          one-cycle hour step pulse
//   minute_id        one-cycle minute step pulse
//   seconds_id       one-cycle seconds step pulse
// ---------------------------------------------------------------------------
module tt_bin_clock_buttons #(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 20
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic time_set_raw,
    input  logic id_switch_raw,
    input  logic hour_btn_raw,
    input  logic minute_btn_raw,
    input  logic seconds_btn_raw,
    output logic time_set,
    output logic id_switch,
    output logic hour_id,
    output logic minute_id,
    output logic seconds_id
);

    localparam int unsigned N_IN   = 5;
    localparam int unsigned N_BTN  = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_TS = 0;
    localparam int unsigned IDX_ID = 1;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] LOCK_HOUR    = 2'd0;
    localparam logic [1:0] LOCK_MINUTE  = 2'd1;
    localparam logic [1:0] LOCK_SECONDS = 2'd2;

    // Reject out-of-range parameter values at elaboration
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
        REPEAT_DELAY < 2    || REPEAT_DELAY > 255    ||
        REPEAT_PERIOD < 2   || REPEAT_PERIOD > 255) begin : g_param_check
        $error("tt_bin_clock_buttons: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Bit order: {seconds, minute, hour, id_switch, time_set}
    logic [N_IN-1:0]  raw_c;
    logic [N_IN-1:0]  sync_q1;
    logic [N_IN-1:0]  sync_q2;
    logic [N_IN-1:0]  db_lvl;
    logic [CNT_W-1:0] db_cnt [N_IN];

    logic [N_BTN-1:0] btn_lvl_c;
    logic [N_BTN-1:0] btn_sync_c;
    logic [N_BTN-1:0] btn_prev;
    logic [N_BTN-1:0] armed;
    logic [N_BTN-1:0] rise_c;
    logic [1:0]       warm;
    logic             warm_done_c;
    logic             held_c;

    state_t           state;
    logic [1:0]       lock;
`ifdef TT_BIN_CLOCK_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rep_cnt;
`endif

    assign raw_c = {seconds_btn_raw, minute_btn_raw, hour_btn_raw,
                    id_switch_raw, time_set_raw};

    // Two-flop synchronisers and per-input debounce counters
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            db_lvl  <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_q1 <= raw_c;
            sync_q2 <= sync_q1;
            for (int i = 0; i < N_IN; i++) begin
                if (sync_q2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= ~db_lvl[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign time_set  = db_lvl[IDX_TS];
    assign id_switch = db_lvl[IDX_ID];

    assign btn_lvl_c   = db_lvl[N_IN-1:N_IN-N_BTN];
    assign btn_sync_c  = sync_q2[N_IN-1:N_IN-N_BTN];
    assign warm_done_c = (warm == 2'd2);

    // A button only arms once it has been seen released after reset, so a
    // button held through reset release cannot produce a rising edge.
    // The synchronisers need two edges after reset before they are valid.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            warm     <= '0;
            armed    <= '0;
            btn_prev <= '0;
        end else begin
            if (!warm_done_c) begin
                warm <= warm + 2'd1;
            end
            if (warm_done_c) begin
                armed <= armed | ~btn_sync_c;
            end
            btn_prev <= btn_lvl_c;
        end
    end

    assign rise_c = btn_lvl_c & ~btn_prev & armed;

    // Debounced level of the locked button
    always_comb begin
        held_c = 1'b0;
        case (lock)
            LOCK_HOUR:    held_c = btn_lvl_c[0];
            LOCK_MINUTE:  held_c = btn_lvl_c[1];
            LOCK_SECONDS: held_c = btn_lvl_c[2];
            default:      held_c = 1'b0;
        endcase
    end

    // Step FSM; pulses default low every cycle so none is wider than one clock
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            lock       <= LOCK_HOUR;
            hour_id    <= 1'b0;
            minute_id  <= 1'b0;
            seconds_id <= 1'b0;
`ifdef TT_BIN_CLOCK_AUTO_REPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            hour_id    <= 1'b0;
            minute_id  <= 1'b0;
            seconds_id <= 1'b0;
            if (!db_lvl[IDX_TS]) begin
                state <= IDLE;
`ifdef TT_BIN_CLOCK_AUTO_REPEAT_EN
                rep_cnt <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (rise_c != '0) begin
                            // Priority seconds > minute > hour
                            if (rise_c[2]) begin
                                lock       <= LOCK_SECONDS;
                                seconds_id <= 1'b1;
                            end else if (rise_c[1]) begin
                                lock      <= LOCK_MINUTE;
                                minute_id <= 1'b1;
                            end else begin
                                lock    <= LOCK_HOUR;
                                hour_id <= 1'b1;
                            end
`ifdef TT_BIN_CLOCK_AUTO_REPEAT_EN
                            rep_cnt <= '0;
                            state   <= DELAY;
`else
                            state   <= HOLD;
`endif
                        end
                    end
`ifdef TT_BIN_CLOCK_AUTO_REPEAT_EN
                    DELAY, REPEAT: begin
                        if (!held_c) begin
                            state   <= IDLE;
                            rep_cnt <= '0;
                        end else if (rep_cnt == ((state == DELAY) ? RD_LAST : RP_LAST)) begin
                            hour_id    <= (lock == LOCK_HOUR);
                            minute_id  <= (lock == LOCK_MINUTE);
                            seconds_id <= (lock == LOCK_SECONDS);
                            rep_cnt    <= '0;
                            state      <= REPEAT;
                        end else begin
                            rep_cnt <= rep_cnt + CNT_W'(1);
                        end
                    end
`endif
                    HOLD: begin
                        if (!held_c) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_bin_clock_buttons.sv
// ---------------------------------------------------------------------------
// tb_tt_bin_clock_buttons
// Self-checking bench for tt_bin_clock_buttons (default 3/50/20). Level
// behaviour is checked from a vector table; step pulses are checked through
// an expected-pulse queue against pulses captured by a monitor.
// ---------------------------------------------------------------------------
module tb_tt_bin_clock_buttons;

    logic clk_i = 1'b0;
    logic reset_i;
    logic time_set_raw, id_switch_raw;
    logic hour_btn_raw, minute_btn_raw, seconds_btn_raw;
    logic time_set, id_switch, hour_id, minute_id, seconds_id;

    tt_bin_clock_buttons dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .time_set_raw    (time_set_raw),
        .id_switch_raw   (id_switch_raw),
        .hour_btn_raw    (hour_btn_raw),
        .minute_btn_raw  (minute_btn_raw),
        .seconds_btn_raw (seconds_btn_raw),
        .time_set        (time_set),
        .id_switch       (id_switch),
        .hour_id         (hour_id),
        .minute_id       (minute_id),
        .seconds_id      (seconds_id)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [2:0] P_HOUR = 3'b001;
    localparam logic [2:0] P_MIN  = 3'b010;
    localparam logic [2:0] P_SEC  = 3'b100;

    typedef struct {
        int         cyc;
        logic [2:0] which;
    } pulse_t;

    typedef struct {
        logic ts;
        logic id;
        int   hold;
        logic exp_ts;
        logic exp_id;
    } vec_t;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     obs_rd = 0;
    logic   multi_hot = 1'b0;
    pulse_t exp_q[$];
    pulse_t obs_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Capture every pulse with the cycle it is visible in
    always @(negedge clk_i) begin
        if ($countones({seconds_id, minute_id, hour_id}) > 1) multi_hot <= 1'b1;
        if ({seconds_id, minute_id, hour_id} != 3'b000)
            obs_q.push_back('{cyc, {seconds_id, minute_id, hour_id}});
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic expect_pulse(input int c, input logic [2:0] w);
        exp_q.push_back('{c, w});
    endtask

    // Compare captured pulses with the expected queue
    task automatic check_seq(input string name);
        int     n_obs;
        int     n_exp;
        pulse_t e;
        pulse_t o;
        n_obs = obs_q.size() - obs_rd;
        n_exp = exp_q.size();
        chk({name, "_count"}, n_obs, n_exp);
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            chk({name, "_cyc"}, o.cyc, e.cyc);
            chk({name, "_which"}, int'(o.which), int'(e.which));
        end
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic chk_outs_zero(input string name);
        chk({name, "_time_set"},   int'(time_set),   0);
        chk({name, "_id_switch"},  int'(id_switch),  0);
        chk({name, "_hour_id"},    int'(hour_id),    0);
        chk({name, "_minute_id"},  int'(minute_id),  0);
        chk({name, "_seconds_id"}, int'(seconds_id), 0);
    endtask

    vec_t vecs[11];

    initial begin
        int c;
        int c2;

        // {ts, id, edges to wait, expected ts, expected id}
        vecs[0]  = '{1'b1, 1'b0, 4, 1'b0, 1'b0};  // one edge before latency
        vecs[1]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0};  // DEBOUNCE+2 edges
        vecs[2]  = '{1'b1, 1'b1, 2, 1'b1, 1'b0};  // 2-cycle glitch on id
        vecs[3]  = '{1'b1, 1'b0, 8, 1'b1, 1'b0};  // glitch never passes
        vecs[4]  = '{1'b1, 1'b1, 4, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 4, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2, 1'b1, 1'b0};  // 2-cycle dropout on ts
        vecs[9]  = '{1'b1, 1'b0, 8, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 6, 1'b1, 1'b1};

        reset_i         = 1'b1;
        time_set_raw    = 1'b0;
        id_switch_raw   = 1'b0;
        hour_btn_raw    = 1'b0;
        minute_btn_raw  = 1'b0;
        seconds_btn_raw = 1'b0;

        step(3);
        chk_outs_zero("in_reset");
        reset_i = 1'b0;
        step(6);
        chk_outs_zero("post_reset");

        // Level debounce table
        for (int i = 0; i < 11; i++) begin
            time_set_raw  = vecs[i].ts;
            id_switch_raw = vecs[i].id;
            step(vecs[i].hold);
            chk($sformatf("vec%0d_time_set", i),  int'(time_set),  int'(vecs[i].exp_ts));
            chk($sformatf("vec%0d_id_switch", i), int'(id_switch), int'(vecs[i].exp_id));
        end
        check_seq("levels_no_pulse");

        // Single press of seconds, held 10 cycles
        c = cyc;
        expect_pulse(c + 6, P_SEC);
        seconds_btn_raw = 1'b1;
        step(10);
        seconds_btn_raw = 1'b0;
        step(12);
        check_seq("sec_single");

        // Minute held 120 cycles
        c = cyc;
        expect_pulse(c + 6, P_MIN);
`ifdef TT_BIN_CLOCK_AUTO_REPEAT_EN
        expect_pulse(c + 56,  P_MIN);
        expect_pulse(c + 76,  P_MIN);
        expect_pulse(c + 96,  P_MIN);
        expect_pulse(c + 116, P_MIN);
`endif
        minute_btn_raw = 1'b1;
        step(120);
        minute_btn_raw = 1'b0;
        step(15);
        check_seq("min_hold");

        // Hour and seconds together: only seconds; hour needs a re-press
        c = cyc;
        expect_pulse(c + 6, P_SEC);
        hour_btn_raw    = 1'b1;
        seconds_btn_raw = 1'b1;
        step(30);
        seconds_btn_raw = 1'b0;
        step(20);
        check_seq("simul_sec_only");
        hour_btn_raw = 1'b0;
        step(10);
        c2 = cyc;
        expect_pulse(c2 + 6, P_HOUR);
        hour_btn_raw = 1'b1;
        step(10);
        hour_btn_raw = 1'b0;
        step(12);
        check_seq("hour_repress");

        // time_set dropped while minute is held, then re-raised
        c = cyc;
        expect_pulse(c + 6, P_MIN);
`ifdef TT_BIN_CLOCK_AUTO_REPEAT_EN
        expect_pulse(c + 56, P_MIN);
        expect_pulse(c + 76, P_MIN);
`endif
        minute_btn_raw = 1'b1;
        step(80);
        time_set_raw = 1'b0;
        step(4);
        chk("ts_drop_before", int'(time_set), 1);
        step(1);
        chk("ts_drop_after", int'(time_set), 0);
        step(5);
        time_set_raw = 1'b1;
        step(5);
        chk("ts_reraise", int'(time_set), 1);
        step(55);
        minute_btn_raw = 1'b0;
        step(15);
        check_seq("ts_drop");

        // Asynchronous reset during a held hour press
        c = cyc;
        expect_pulse(c + 6, P_HOUR);
        hour_btn_raw = 1'b1;
        step(20);
        #3;
        reset_i = 1'b1;
        #1;
        chk_outs_zero("async_reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        step(30);
        chk("ts_after_reset", int'(time_set), 1);
        check_seq("reset_held");
        hour_btn_raw = 1'b0;
        step(10);
        c2 = cyc;
        expect_pulse(c2 + 6, P_HOUR);
        hour_btn_raw = 1'b1;
        step(8);
        hour_btn_raw = 1'b0;
        step(12);
        check_seq("reset_repress");

        chk("one_hot", int'(multi_hot), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
